// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the 8-bit datapath. Holds the program counter, runs a
// request/acknowledge handshake with instruction memory and latches each
// returned instruction byte, exposing its opcode / rd / imm fields for decode.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   mem_req        fetch request (high in FETCH)
//   mem_addr       fetch address (always the current pc)
//   mem_ack        memory response, mem_rdata valid in the same cycle
//   mem_rdata      instruction byte from memory
//   stall          downstream not ready; holds the current instruction
//   branch_taken   redirect request from execute (one-cycle pulse)
//   branch_target  redirect address
//   instr          latched instruction
//   opcode         instr[7:4]
//   rd             instr[3:2]
//   imm            instr[1:0], feeds the zero-extension stage
//   instr_pc       address instr was fetched from
//   instr_valid    instr and its fields are valid (high in VALID)
//   pc             next fetch address
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic [7:0] instr,
    output logic [3:0] opcode,
    output logic [1:0] rd,
    output logic [1:0] imm,
    output logic [7:0] instr_pc,
    output logic       instr_valid,
    output logic [7:0] pc
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] pc_r;
    logic [7:0] pc_s;
    logic [7:0] instr_r;
    logic [7:0] instr_s;
    logic [7:0] instr_pc_r;
    logic [7:0] instr_pc_s;

    // Next-state and next-register computation; everything holds by default.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        instr_s    = instr_r;
        instr_pc_s = instr_pc_r;
        case (state_r)
            ST_FETCH: begin
                if (branch_taken) begin
                    // Redirect wins; any data returned this cycle is dropped.
                    pc_s = branch_target;
                end else if (mem_ack) begin
                    instr_s    = mem_rdata;
                    instr_pc_s = pc_r;
                    pc_s       = pc_r + 8'd1;  // 8-bit wrap, no carry out
                    state_s    = ST_VALID;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_VALID: begin
                if (branch_taken) begin
                    // Flush has priority over stall.
                    pc_s    = branch_target;
                    state_s = ST_FETCH;
                end else if (stall) begin
                    state_s = ST_VALID;
                end else begin
                    // instr keeps its value; only the valid flag drops.
                    state_s = ST_FETCH;
                end
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            instr_r    <= 8'h00;
            instr_pc_r <= 8'h00;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            instr_r    <= instr_s;
            instr_pc_r <= instr_pc_s;
        end
    end

    // Handshake and valid flags come straight from the state register so
    // that no input reaches them combinationally.
    assign mem_req     = (state_r == ST_FETCH);
    assign instr_valid = (state_r == ST_VALID);
    assign mem_addr    = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign opcode      = instr_r[7:4];
    assign rd          = instr_r[3:2];
    assign imm         = instr_r[1:0];

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the 8-bit datapath. It holds the program counter, runs a request/acknowledge handshake with instruction memory, and latches each 8-bit instruction. It splits the latched instruction into opcode, destination register and 2-bit immediate fields. The `imm` field feeds the zero-extension stage directly, which widens it to 8 bits for the ALU operand mux.

## Interface
Parameters:
- `RESET_PC`, default 8'h00: PC value loaded on reset.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `mem_req`, output, 1: fetch request to instruction memory.
- `mem_addr`, output, 8: fetch address. Equals `pc` whenever `mem_req` = 1.
- `mem_ack`, input, 1: memory response. `mem_rdata` is valid in the same cycle.
- `mem_rdata`, input, 8: instruction byte from memory.
- `stall`, input, 1: downstream not ready. Holds the current instruction.
- `branch_taken`, input, 1: redirect request from the execute stage.
- `branch_target`, input, 8: redirect address.
- `instr`, output, 8: latched instruction.
- `opcode`, output, 4: `instr[7:4]`.
- `rd`, output, 2: `instr[3:2]`.
- `imm`, output, 2: `instr[1:0]`, the zero-extension input.
- `instr_pc`, output, 8: address the current `instr` was fetched from.
- `instr_valid`, output, 1: `instr` and its fields are valid for decode.
- `pc`, output, 8: next fetch address.

## Operation
- Two-state FSM: FETCH and VALID. `mem_req` = (state == FETCH). `instr_valid` = (state == VALID). Both are decoded from the state register, with no combinational path from inputs.
- FETCH:
  - `mem_req` is held high and `mem_addr` = `pc` until `mem_ack`.
  - On `mem_ack` without `branch_taken`: `instr` <= `mem_rdata`, `instr_pc` <= `pc`, `pc` <= `pc` + 1, go to VALID.
  - With `branch_taken` (with or without `mem_ack`): `pc` <= `branch_target`, any returned data is discarded, and the state stays FETCH.
- VALID:
  - `branch_taken` = 1: `pc` <= `branch_target`, go to FETCH. This flush has priority over `stall`.
  - `stall` = 1 and no branch: all registers hold.
  - `stall` = 0 and no branch: go to FETCH. `instr` keeps its value but `instr_valid` drops.
- PC arithmetic is 8-bit modulo. 8'hFF + 1 = 8'h00, with no flag.
- `mem_ack` is ignored in VALID.
- `opcode`, `rd` and `imm` are pure slices of the `instr` register and carry no extra delay.
- Reset values: state = FETCH, `pc` = `RESET_PC`, `instr` = 8'h00, `instr_pc` = 8'h00, `instr_valid` = 0.
  - `mem_req` is therefore 1 in the first cycle after the reset edge.
- Reset mid-operation, in either state: all registers return to reset values on that edge. Pending memory data is dropped. Memory must tolerate request withdrawal.

## Timing
- Fetch latency: `instr_valid` rises on the edge that samples `mem_ack`. With a zero-wait memory (ack in the first request cycle), throughput is one instruction per 2 cycles.
- Each extra memory wait cycle adds one cycle.
- `stall` sampled high in VALID holds `instr_valid` for another cycle.
- Branch redirect:
  - The new `pc` is visible the cycle after `branch_taken` is sampled.
  - The first request to `branch_target` is issued in that cycle.
  - The earliest valid target instruction is 2 cycles after `branch_taken` (zero-wait memory).
- `branch_taken` is a one-cycle pulse. When held, it is re-sampled each cycle and re-redirects.

## Test plan
- Reset and first fetch: reset high 2 cycles, then low, with memory returning 8'hB6 at address 0 with zero wait. Required:
  - `mem_req` = 1 and `mem_addr` = 8'h00 in the first cycle after reset.
  - Next cycle: `instr_valid` = 1, `instr` = 8'hB6, `opcode` = 4'hB, `rd` = 2'b01, `imm` = 2'b10, `instr_pc` = 8'h00, `pc` = 8'h01.
- Wait states: ack delayed 3 cycles. Required: `mem_req` and `mem_addr` are stable for 4 cycles, `instr_valid` rises once, and `pc` increments exactly once.
- Stall: `stall` = 1 for 3 cycles in VALID. Required: `instr`, `pc` and `instr_valid` = 1 are held, and `mem_req` = 0 throughout. After release, a fetch at `pc` follows.
- Branch flush: `branch_taken` = 1 with target 8'h40 while in VALID with `stall` = 1. Required:
  - Next cycle `instr_valid` = 0, `pc` = 8'h40, `mem_addr` = 8'h40.
  - The following instruction has `instr_pc` = 8'h40.
- Branch during fetch: `mem_ack` and `branch_taken` (target 8'h10) in the same cycle. Required: `mem_rdata` is discarded, `instr` is unchanged, and the next request is to 8'h10.
- Wrap and mid-fetch reset:
  - `pc` = 8'hFF fetch: `pc` becomes 8'h00 after ack.
  - Reset asserted during a wait-state fetch: `pc` = `RESET_PC` and `instr_valid` = 0 on the next edge.
